// File: rtl/pixel_fetch_sequencer.sv
// Fetches 32-bit words for one scan span and steps the pixel lane index through
// each word by colour depth, handing pixels to the colour converter via valid/ready.
module pixel_fetch_sequencer #(
   parameter int AW = 30,
   parameter int CW = 16
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          start_i,
   input  logic [1:0]    color_depth_i,
   input  logic [AW-1:0] base_adr_i,
   input  logic [CW-1:0] pix_count_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic          mem_req_o,
   output logic [AW-1:0] mem_adr_o,
   input  logic          mem_ack_i,
   input  logic [31:0]   mem_dat_i,
   output logic          pix_valid_o,
   input  logic          pix_ready_i,
   output logic [31:0]   pix_word_o,
   output logic [1:0]    pix_lsb_o,
   output logic [1:0]    pix_depth_o,
   output logic          pix_last_o
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT} state_t;

   state_t        r_state;
   logic [1:0]    r_depth;
   logic [1:0]    r_lsb;
   logic [AW-1:0] r_adr;
   logic [CW-1:0] r_remain;
   logic [31:0]   r_word;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic          r_req;
   logic          r_valid;
   logic          w_lane_last;

   // Last lane of a word: 8bpp uses lanes 0..3, 16bpp 0..1, 32bpp lane 0 only.
   always_comb begin
      w_lane_last = 1'b1;
      unique case (r_depth)
         2'd0:    w_lane_last = (r_lsb == 2'd3);
         2'd1:    w_lane_last = (r_lsb == 2'd1);
         default: w_lane_last = 1'b1;
      endcase
   end

   // NOTE: every register here is updated with <= so all state changes on the same edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= S_IDLE;
         r_depth  <= 2'd0;
         r_lsb    <= 2'd0;
         r_adr    <= '0;
         r_remain <= '0;
         r_word   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  if (color_depth_i == 2'd3) begin
                     r_err <= 1'b1;
                  end else if (pix_count_i == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_depth  <= color_depth_i;
                     r_adr    <= base_adr_i;
                     r_remain <= pix_count_i;
                     r_lsb    <= 2'd0;
                     r_busy   <= 1'b1;
                     r_req    <= 1'b1;
                     r_state  <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (mem_ack_i) begin
                  r_word  <= mem_dat_i;
                  r_adr   <= r_adr + AW'(1);
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (pix_ready_i) begin
                  r_remain <= r_remain - CW'(1);
                  if (r_remain == CW'(1)) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else if (w_lane_last) begin
                     r_lsb   <= 2'd0;
                     r_valid <= 1'b0;
                     r_req   <= 1'b1;
                     r_state <= S_FETCH;
                  end else begin
                     r_lsb <= r_lsb + 2'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign mem_req_o   = r_req;
   assign mem_adr_o   = r_adr;
   assign pix_valid_o = r_valid;
   assign pix_word_o  = r_word;
   assign pix_lsb_o   = r_lsb;
   assign pix_depth_o = r_depth;
   assign pix_last_o  = r_valid && (r_remain == CW'(1));

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Scoreboard bench for pixel_fetch_sequencer: spans are expanded into expected
// read addresses and pixels; a negedge monitor drives ready/ack and compares.
module tb_pixel_fetch_sequencer;
   localparam int AW = 30;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    depth = 2'd0;
   logic [AW-1:0] base = '0;
   logic [CW-1:0] count = '0;
   logic          busy, done, err, req, valid, last;
   logic [AW-1:0] adr;
   logic          ack = 1'b0;
   logic [31:0]   dat = '0;
   logic          ready = 1'b0;
   logic [31:0]   word;
   logic [1:0]    lsb, pdepth;

   pixel_fetch_sequencer #(.AW(AW), .CW(CW)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .color_depth_i(depth),
      .base_adr_i(base), .pix_count_i(count), .busy_o(busy), .done_o(done),
      .err_o(err), .mem_req_o(req), .mem_adr_o(adr), .mem_ack_i(ack),
      .mem_dat_i(dat), .pix_valid_o(valid), .pix_ready_i(ready),
      .pix_word_o(word), .pix_lsb_o(lsb), .pix_depth_o(pdepth), .pix_last_o(last)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] word;
      logic [1:0]  lsb;
      logic [1:0]  depth;
      logic        last;
   } pix_t;

   pix_t          exp_pix_q[$];
   logic [AW-1:0] exp_adr_q[$];
   int n_tests = 0, n_fail = 0;
   int done_seen = 0, err_seen = 0;
   int ready_mode = 0, ack_min = 0, ack_max = 0;

   function automatic logic [31:0] mem_model(input logic [AW-1:0] a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: DUT produced an item with nothing expected (t=%0t)", name, $time);
   endtask

   // Monitor + responder: drives ready/ack for the next edge and scores handshakes.
   always @(negedge clk) begin : mon
      int   wait_cnt, cur_delay;
      logic p_valid, p_ready, p_req, p_ack, p_done, p_err, p_last;
      logic [31:0] p_word;
      logic [1:0]  p_lsb;
      logic [AW-1:0] p_adr;
      pix_t e, a;
      if (!rst_n) begin
         ready = 1'b0; ack = 1'b0; wait_cnt = 0;
         p_valid = 1'b0; p_req = 1'b0; p_done = 1'b0; p_err = 1'b0;
      end else begin
         if (p_valid && !p_ready) begin
            check("pix_hold_valid", 64'(valid), 64'd1);
            check("pix_hold_data", {word, lsb, last}, {p_word, p_lsb, p_last});
         end
         if (p_req && !p_ack) check("req_hold", {req, adr}, {1'b1, p_adr});
         if (valid || req) check("one_outstanding", 64'(valid & req), 64'd0);
         if (done) begin done_seen++; check("done_pulse_width", 64'(p_done), 64'd0); end
         if (err)  begin err_seen++;  check("err_pulse_width", 64'(p_err), 64'd0); end

         case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = 1'($urandom_range(1, 0));
         endcase
         if (req) begin
            if (wait_cnt == 0) cur_delay = $urandom_range(ack_max, ack_min);
            if (wait_cnt >= cur_delay) begin
               ack = 1'b1; dat = mem_model(adr); wait_cnt = 0;
            end else begin
               ack = 1'b0; wait_cnt++;
            end
         end else begin
            ack = ($urandom_range(3, 0) == 0);
            dat = $urandom;
            wait_cnt = 0;
         end

         if (valid && ready) begin
            if (exp_pix_q.size() == 0) fail_now("pix_unexpected");
            else begin
               e = exp_pix_q.pop_front();
               a = '{word: word, lsb: lsb, depth: pdepth, last: last};
               check("pixel", 64'(a), 64'(e));
            end
         end
         if (req && ack) begin
            if (exp_adr_q.size() == 0) fail_now("read_unexpected");
            else check("read_adr", 64'(adr), 64'(exp_adr_q.pop_front()));
         end

         p_valid = valid; p_ready = ready; p_req = req; p_ack = ack;
         p_done = done; p_err = err; p_word = word; p_lsb = lsb;
         p_last = last; p_adr = adr;
      end
   end

   task automatic run_span(input logic [1:0] d, input logic [AW-1:0] b, input logic [CW-1:0] c,
                           input int rmode, input int amin, input int amax);
      int  ppw, dn0, er0;
      bit  got;
      ready_mode = rmode; ack_min = amin; ack_max = amax;
      dn0 = done_seen; er0 = err_seen;
      if (d != 2'd3 && c != 0) begin
         ppw = 4 >> d;
         for (int k = 0; k < int'(c); k++) begin
            logic [AW-1:0] wa;
            wa = b + AW'(k / ppw);
            if (k % ppw == 0) exp_adr_q.push_back(wa);
            exp_pix_q.push_back('{word: mem_model(wa), lsb: 2'(k % ppw), depth: d,
                                  last: (k == int'(c) - 1)});
         end
      end
      @(negedge clk);
      start = 1'b1; depth = d; base = b; count = c;
      @(negedge clk);
      start = 1'b0; depth = 2'($urandom); base = AW'($urandom); count = CW'($urandom);
      if (d == 2'd3) check("err_start", {err, done, busy, req}, 64'b1000);
      else if (c == 0) check("zero_count_start", {err, done, busy, req}, 64'b0100);
      else begin
         check("start_busy_req", {busy, req, valid}, 64'b110);
         check("start_adr", 64'(adr), 64'(b));
         got = 1'b0;
         for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; start = 1'b0; end
            else start = 1'($urandom_range(1, 0));
         end
         start = 1'b0;
         check("span_done", 64'(got), 64'd1);
         check("done_idle", {busy, req, valid}, 64'b000);
      end
      repeat (2) @(negedge clk);
      check("done_count", 64'(done_seen - dn0), (d != 2'd3) ? 64'd1 : 64'd0);
      check("err_count", 64'(err_seen - er0), (d == 2'd3) ? 64'd1 : 64'd0);
      check("queues_drained", 64'(exp_pix_q.size() + exp_adr_q.size()), 64'd0);
   endtask

   initial begin
      int dn0;
      repeat (2) @(negedge clk);
      check("reset_ctl", {busy, done, err, req, valid, last, lsb, pdepth}, 64'd0);
      check("reset_data", {adr, word}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_span(2'd0, AW'('h100), CW'(6), 0, 0, 0);
      run_span(2'd1, AW'('h2345), CW'(3), 1, 0, 0);
      run_span(2'd2, AW'('h777), CW'(2), 0, 5, 5);
      run_span(2'd3, AW'('h10), CW'(5), 0, 0, 0);
      run_span(2'd0, AW'('h10), CW'(0), 0, 0, 0);
      run_span(2'd2, {AW{1'b1}}, CW'(2), 0, 0, 2);
      run_span(2'd0, {AW{1'b1}} - AW'(1), CW'(11), 2, 0, 3);

      // Reset in the middle of a fetch, with start held high while busy.
      ready_mode = 0; ack_min = 20; ack_max = 20;
      @(negedge clk);
      start = 1'b1; depth = 2'd2; base = AW'('h55); count = CW'(4);
      @(negedge clk);
      check("rst_test_fetch", {busy, req}, 64'b11);
      depth = 2'd0; count = CW'(1);
      repeat (3) @(negedge clk);
      check("rst_test_still_req", {busy, req, valid}, 64'b110);
      dn0 = done_seen;
      #1 rst_n = 1'b0;
      #1;
      check("mid_reset_ctl", {busy, done, err, req, valid, last, lsb, pdepth}, 64'd0);
      check("mid_reset_data", {adr, word}, 64'd0);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_reset_no_done", 64'(done_seen - dn0), 64'd0);
      check("mid_reset_idle", {busy, req}, 64'b00);
      run_span(2'd1, AW'('h200), CW'(5), 2, 0, 3);

      for (int s = 0; s < 40; s++) begin
         logic [1:0] d;
         d = ($urandom_range(9, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
         run_span(d, AW'($urandom), CW'($urandom_range(20, 0)),
                  $urandom_range(2, 0), 0, $urandom_range(4, 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
